ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  Execute stage and EX/MEM pipeline register of the pipelined MIPS core; consumes ID/EX buffer fields.
//  Single-cycle ALU ops; iterative 32-step MULT with upstream stall; registered results feed MEM.
//  Produces ALU result, store data, branch target, zero flag and destination register.
// PARAMETERS
//  DATA_W  32  datapath width; MULT iteration count = DATA_W
//  REG_W   5   register-index width
// PORTS
//  clk        in   1       clock, all state on rising edge
//  reset      in   1       synchronous, active-high
//  flush      in   1       sync kill of instruction in EX (branch mispredict)
//  in_valid   in   1       ID/EX holds a real instruction
//  wb_in      in   2       WB control, passed through
//  m_in       in   3       MEM control, passed through
//  reg_dst    in   1       1: dest = rd_in, 0: dest = rt_in
//  alu_op     in   3       ALU operation class (see BEHAVIOUR)
//  alu_src    in   1       1: operand2 = imm_in, 0: operand2 = rt_data
//  pc4_in     in   DATA_W  PC+4
//  rs_data    in   DATA_W  operand1
//  rt_data    in   DATA_W  operand2 / store data
//  imm_in     in   DATA_W  sign-extended immediate; [5:0] = funct for R-type
//  rt_in      in   REG_W   rt index
//  rd_in      in   REG_W   rd index
//  stall      out  1       hold IF/ID and ID/EX (combinational)
//  out_valid  out  1       EX/MEM holds a real instruction
//  wb_out     out  2       registered wb_in; 0 when out_valid=0
//  m_out      out  3       registered m_in; 0 when out_valid=0
//  alu_res    out  DATA_W  result
//  store_data out  DATA_W  registered rt_data
//  br_target  out  DATA_W  pc4_in + (imm_in<<2), mod 2^DATA_W
//  zero       out  1       alu_res == 0
//  write_reg  out  REG_W   selected destination
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counter 0. Priority: reset > flush > normal.
//  alu_op: 000 add, 001 sub, 010 R-type by funct, 011 and, 100 or, 101 slt (signed), 110 lui (imm<<16), 111 -> result 0.
//  funct: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt, 011000 mult; other -> 0.
//  add/sub wrap modulo 2^DATA_W, no overflow trap.
//  FSM IDLE: in_valid & non-mult -> EX/MEM loads next edge, out_valid=1 (latency 1).
//   in_valid=0 -> bubble: out_valid/wb_out/m_out=0; datapath outputs hold previous value.
//   in_valid & mult -> capture operands + control, cnt=0, go MUL; EX/MEM gets bubble.
//  FSM MUL: one shift-add step per cycle, cnt 0..31; EX/MEM gets bubble each cycle.
//   edge ending cnt==31: load product low DATA_W bits + captured control, out_valid=1, go IDLE.
//  stall = (IDLE & in_valid & mult) | (MUL & cnt!=31); low in last MUL cycle so ID/EX advances at completion.
//  Mult: 32 stall cycles, result visible 33 edges after capture edge start.
//  flush: next edge out_valid/wb_out/m_out=0, MUL aborted -> IDLE, cnt=0, stall=0 next cycle.
//  reset mid-MUL: same as reset; no partial result ever reaches outputs.
//  zero and write_reg computed from the same instruction as alu_res.
// TESTING
//  reset held 2 cycles -> all outputs 0, stall=0, out_valid=0
//  alu_op=010 funct=100000 rs=5 rt=7 reg_dst=1 rd=9 wb=10 -> next edge alu_res=12, write_reg=9, wb_out=10, zero=0
//  alu_op=001 rs=rt=3 pc4=0x100 imm=4 -> zero=1, br_target=0x110, alu_res=0
//  alu_op=000 alu_src=1 rs=0x1000 imm=0xFFFFFFFC -> alu_res=0xFFC; reg_dst=0 -> write_reg=rt_in
//  mult rs=0x10000 rt=0x10001 -> stall high 32 cycles, out_valid=0 throughout, then alu_res=0x00010000, out_valid=1 one cycle
//  flush at MUL cnt=10 (repeat with reset) -> next cycle IDLE, stall=0, out_valid=0, no mult result emitted

Source files
------------

// File: rtl/ex_mem_stage.sv
// ============================================================================
//  Module      : ex_mem_stage
//  Description : MIPS execute stage with EX/MEM pipeline register; single-cycle
//                ALU plus an iterative shift-add MULT that stalls upstream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [1:0]        wb_in,
  input  logic [2:0]        m_in,
  input  logic              reg_dst,
  input  logic [2:0]        alu_op,
  input  logic              alu_src,
  input  logic [DATA_W-1:0] pc4_in,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [REG_W-1:0]  rt_in,
  input  logic [REG_W-1:0]  rd_in,
  output logic              stall,
  output logic              out_valid,
  output logic [1:0]        wb_out,
  output logic [2:0]        m_out,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] br_target,
  output logic              zero,
  output logic [REG_W-1:0]  write_reg
);

  localparam int                c_CNT_W    = $clog2(DATA_W);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_W - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  localparam logic [5:0] c_F_ADD  = 6'b100000;
  localparam logic [5:0] c_F_SUB  = 6'b100010;
  localparam logic [5:0] c_F_AND  = 6'b100100;
  localparam logic [5:0] c_F_OR   = 6'b100101;
  localparam logic [5:0] c_F_XOR  = 6'b100110;
  localparam logic [5:0] c_F_NOR  = 6'b100111;
  localparam logic [5:0] c_F_SLT  = 6'b101010;
  localparam logic [5:0] c_F_MULT = 6'b011000;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t              state_q;
  logic [c_CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0]   acc_q, mcand_q, mplier_q;
  logic [1:0]          cap_wb_q;
  logic [2:0]          cap_m_q;
  logic [DATA_W-1:0]   cap_store_q, cap_br_q;
  logic [REG_W-1:0]    cap_wreg_q;

  logic              out_valid_q, zero_q;
  logic [1:0]        wb_q;
  logic [2:0]        m_q;
  logic [DATA_W-1:0] alu_res_q, store_q, br_q;
  logic [REG_W-1:0]  wreg_q;

  logic [DATA_W-1:0] w_op2, alu_res_d, br_d, acc_d;
  logic [REG_W-1:0]  dest_d;
  logic              w_is_mult, w_slt;

  assign w_op2     = alu_src ? imm_in : rt_data;
  assign w_is_mult = (alu_op == 3'b010) && (imm_in[5:0] == c_F_MULT);
  assign w_slt     = $signed(rs_data) < $signed(w_op2);
  assign br_d      = pc4_in + (imm_in << 2);
  assign dest_d    = reg_dst ? rd_in : rt_in;
  // One multiplier bit consumed per cycle, LSB first
  assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    alu_res_d = '0;
    case (alu_op)
      3'b000: alu_res_d = rs_data + w_op2;
      3'b001: alu_res_d = rs_data - w_op2;
      3'b010: begin
        case (imm_in[5:0])
          c_F_ADD: alu_res_d = rs_data + w_op2;
          c_F_SUB: alu_res_d = rs_data - w_op2;
          c_F_AND: alu_res_d = rs_data & w_op2;
          c_F_OR:  alu_res_d = rs_data | w_op2;
          c_F_XOR: alu_res_d = rs_data ^ w_op2;
          c_F_NOR: alu_res_d = ~(rs_data | w_op2);
          c_F_SLT: alu_res_d = {{(DATA_W-1){1'b0}}, w_slt};
          default: alu_res_d = '0;
        endcase
      end
      3'b011: alu_res_d = rs_data & w_op2;
      3'b100: alu_res_d = rs_data | w_op2;
      3'b101: alu_res_d = {{(DATA_W-1){1'b0}}, w_slt};
      3'b110: alu_res_d = imm_in << 16;
      default: alu_res_d = '0;
    endcase
  end

  // Stall drops in the last MUL cycle so ID/EX advances on the completion edge
  assign stall = ((state_q == S_IDLE) && in_valid && w_is_mult) ||
                 ((state_q == S_MUL) && (cnt_q != c_CNT_LAST));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cap_wb_q    <= '0;
      cap_m_q     <= '0;
      cap_store_q <= '0;
      cap_br_q    <= '0;
      cap_wreg_q  <= '0;
      out_valid_q <= 1'b0;
      wb_q        <= '0;
      m_q         <= '0;
      alu_res_q   <= '0;
      store_q     <= '0;
      br_q        <= '0;
      zero_q      <= 1'b0;
      wreg_q      <= '0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      wb_q        <= '0;
      m_q         <= '0;
    end else begin
      out_valid_q <= 1'b0;
      wb_q        <= '0;
      m_q         <= '0;
      case (state_q)
        S_IDLE: begin
          if (in_valid && w_is_mult) begin
            state_q     <= S_MUL;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= rs_data;
            mplier_q    <= w_op2;
            cap_wb_q    <= wb_in;
            cap_m_q     <= m_in;
            cap_store_q <= rt_data;
            cap_br_q    <= br_d;
            cap_wreg_q  <= dest_d;
          end else if (in_valid) begin
            out_valid_q <= 1'b1;
            wb_q        <= wb_in;
            m_q         <= m_in;
            alu_res_q   <= alu_res_d;
            store_q     <= rt_data;
            br_q        <= br_d;
            zero_q      <= (alu_res_d == '0);
            wreg_q      <= dest_d;
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + c_CNT_ONE;
          if (cnt_q == c_CNT_LAST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            wb_q        <= cap_wb_q;
            m_q         <= cap_m_q;
            alu_res_q   <= acc_d;
            store_q     <= cap_store_q;
            br_q        <= cap_br_q;
            zero_q      <= (acc_d == '0);
            wreg_q      <= cap_wreg_q;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign wb_out     = wb_q;
  assign m_out      = m_q;
  assign alu_res    = alu_res_q;
  assign store_data = store_q;
  assign br_target  = br_q;
  assign zero       = zero_q;
  assign write_reg  = wreg_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
// ============================================================================
//  Module      : tb_ex_mem_stage
//  Description : Self-checking bench for ex_mem_stage against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, reg_dst, alu_src;
  logic [1:0]  wb_in;
  logic [2:0]  m_in, alu_op;
  logic [31:0] pc4_in, rs_data, rt_data, imm_in;
  logic [4:0]  rt_in, rd_in;
  logic        stall, out_valid, zero;
  logic [1:0]  wb_out;
  logic [2:0]  m_out;
  logic [31:0] alu_res, store_data, br_target;
  logic [4:0]  write_reg;

  int checks = 0;
  int errors = 0;

  ex_mem_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .wb_in(wb_in), .m_in(m_in), .reg_dst(reg_dst), .alu_op(alu_op),
    .alu_src(alu_src), .pc4_in(pc4_in), .rs_data(rs_data), .rt_data(rt_data),
    .imm_in(imm_in), .rt_in(rt_in), .rd_in(rd_in), .stall(stall),
    .out_valid(out_valid), .wb_out(wb_out), .m_out(m_out), .alu_res(alu_res),
    .store_data(store_data), .br_target(br_target), .zero(zero),
    .write_reg(write_reg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural ALU: the arithmetic each opcode is defined to produce
  function automatic logic [31:0] model_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] imm);
    logic [5:0] f;
    f = imm[5:0];
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: begin
        if (f == 6'h20) return a + b;
        if (f == 6'h22) return a - b;
        if (f == 6'h24) return a & b;
        if (f == 6'h25) return a | b;
        if (f == 6'h26) return a ^ b;
        if (f == 6'h27) return ~(a | b);
        if (f == 6'h2a) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        if (f == 6'h18) return a * b;
        return 32'd0;
      end
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return {imm[15:0], 16'h0000};
      default: return 32'd0;
    endcase
  endfunction

  task automatic idle_inputs();
    reset = 0; flush = 0; in_valid = 0; reg_dst = 0; alu_src = 0;
    wb_in = 0; m_in = 0; alu_op = 0; pc4_in = 0; rs_data = 0; rt_data = 0;
    imm_in = 0; rt_in = 0; rd_in = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    in_valid = 1; alu_op = 3'd0; rs_data = 32'h55; rt_data = 32'h1; wb_in = 2'b11; m_in = 3'b111;
    reset = 1;
    step(); step();
    checks++;
    if ({out_valid, wb_out, m_out, zero} !== 7'd0 || alu_res !== 0 || store_data !== 0 ||
        br_target !== 0 || write_reg !== 0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b wb=%0d m=%0d res=%h st=%h br=%h z=%0b wr=%0d, want all 0",
               out_valid, wb_out, m_out, alu_res, store_data, br_target, zero, write_reg);
    end
    idle_inputs();
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", stall); end
  endtask

  task automatic test_alu_directed();
    idle_inputs();
    in_valid = 1; alu_op = 3'b010; imm_in = 32'h20; rs_data = 5; rt_data = 7;
    reg_dst = 1; rd_in = 9; rt_in = 3; wb_in = 2'b10;
    step();
    checks++;
    if (out_valid !== 1 || alu_res !== 32'd12 || write_reg !== 5'd9 || wb_out !== 2'b10 || zero !== 0) begin
      errors++;
      $display("FAIL rtype_add: got v=%0b res=%0d wr=%0d wb=%0d z=%0b want 1/12/9/2/0",
               out_valid, alu_res, write_reg, wb_out, zero);
    end

    alu_op = 3'b001; rs_data = 3; rt_data = 3; pc4_in = 32'h100; imm_in = 4; alu_src = 0;
    step();
    checks++;
    if (zero !== 1 || br_target !== 32'h110 || alu_res !== 0 || store_data !== 3) begin
      errors++;
      $display("FAIL sub_zero: got z=%0b br=%h res=%h st=%h want 1/110/0/3", zero, br_target, alu_res, store_data);
    end

    alu_op = 3'b000; alu_src = 1; rs_data = 32'h1000; imm_in = 32'hFFFF_FFFC; reg_dst = 0; rt_in = 17;
    step();
    checks++;
    if (alu_res !== 32'hFFC || write_reg !== 5'd17 || br_target !== 32'h0000_00F0) begin
      errors++;
      $display("FAIL add_imm: got res=%h wr=%0d br=%h want ffc/17/000000f0", alu_res, write_reg, br_target);
    end

    in_valid = 0; wb_in = 2'b11; m_in = 3'b101;
    step();
    checks++;
    if (out_valid !== 0 || wb_out !== 0 || m_out !== 0 || alu_res !== 32'hFFC || write_reg !== 5'd17) begin
      errors++;
      $display("FAIL bubble_hold: got v=%0b wb=%0d m=%0d res=%h wr=%0d want 0/0/0/ffc/17",
               out_valid, wb_out, m_out, alu_res, write_reg);
    end

    alu_op = 3'b110; in_valid = 1; imm_in = 32'h0000_ABCD; alu_src = 1; m_in = 3'b010;
    step();
    checks++;
    if (alu_res !== 32'hABCD_0000 || m_out !== 3'b010) begin
      errors++;
      $display("FAIL lui: got res=%h m=%0d want abcd0000/2", alu_res, m_out);
    end
    idle_inputs();
  endtask

  task automatic test_random_alu();
    logic [5:0]  functs [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h3f};
    logic        e_valid, known, e_zero;
    logic [1:0]  e_wb;
    logic [2:0]  e_m;
    logic [31:0] e_res, e_st, e_br, b;
    logic [4:0]  e_wr;
    known = 0; e_res = 0; e_st = 0; e_br = 0; e_wr = 0; e_zero = 0;
    for (int i = 0; i < 80; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 9) == 0);
      alu_op   = 3'($urandom_range(0, 7));
      alu_src  = (alu_op == 3'd2) ? 1'b0 : 1'($urandom_range(0, 1));
      rs_data  = $urandom(); rt_data = $urandom(); pc4_in = $urandom();
      imm_in   = $urandom();
      if (alu_op == 3'd2) imm_in[5:0] = functs[$urandom_range(0, 7)];
      if (i % 7 == 0) rt_data = rs_data;
      reg_dst  = 1'($urandom_range(0, 1));
      rt_in    = 5'($urandom()); rd_in = 5'($urandom());
      wb_in    = 2'($urandom()); m_in = 3'($urandom());
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL rand_stall[%0d]: got %0b want 0", i, stall); end
      b = alu_src ? imm_in : rt_data;
      if (flush) begin
        e_valid = 0; e_wb = 0; e_m = 0; known = 0;
      end else if (in_valid) begin
        e_valid = 1; e_wb = wb_in; e_m = m_in; known = 1;
        e_res = model_alu(alu_op, rs_data, b, imm_in);
        e_st = rt_data; e_br = pc4_in + imm_in * 4; e_zero = (e_res == 0);
        e_wr = reg_dst ? rd_in : rt_in;
      end else begin
        e_valid = 0; e_wb = 0; e_m = 0;
      end
      step();
      checks++;
      if (out_valid !== e_valid || wb_out !== e_wb || m_out !== e_m) begin
        errors++;
        $display("FAIL rand_ctl[%0d]: got v=%0b wb=%0d m=%0d want %0b/%0d/%0d",
                 i, out_valid, wb_out, m_out, e_valid, e_wb, e_m);
      end
      if (known) begin
        checks++;
        if (alu_res !== e_res || store_data !== e_st || br_target !== e_br || zero !== e_zero || write_reg !== e_wr) begin
          errors++;
          $display("FAIL rand_data[%0d]: got res=%h st=%h br=%h z=%0b wr=%0d want %h/%h/%h/%0b/%0d",
                   i, alu_res, store_data, br_target, zero, write_reg, e_res, e_st, e_br, e_zero, e_wr);
        end
      end
    end
    idle_inputs();
  endtask

  // Issue a MULT and hold it in ID/EX until stall drops; returns stall-cycle count
  task automatic issue_mult(input logic [31:0] a, input logic [31:0] bb, output int stalls);
    in_valid = 1; alu_op = 3'b010; alu_src = 0; imm_in = 32'h0000_0018;
    rs_data = a; rt_data = bb;
    #1;
    stalls = 0;
    while (stall === 1'b1 && stalls < 40) begin
      stalls++;
      step();
      checks++;
      if (out_valid !== 0) begin errors++; $display("FAIL mult_busy_valid: got %0b want 0", out_valid); end
    end
  endtask

  task automatic test_mult();
    int n;
    idle_inputs();
    wb_in = 2'b01; m_in = 3'b101; reg_dst = 1; rd_in = 12; pc4_in = 32'h200; imm_in = 32'h18;
    issue_mult(32'h0001_0000, 32'h0001_0001, n);
    checks++;
    if (n != 32) begin errors++; $display("FAIL mult_stall_cycles: got %0d want 32", n); end
    step();
    checks++;
    if (out_valid !== 1 || alu_res !== 32'h0001_0000 || wb_out !== 2'b01 || m_out !== 3'b101 ||
        write_reg !== 5'd12 || store_data !== 32'h0001_0001 || br_target !== 32'h260 || zero !== 0) begin
      errors++;
      $display("FAIL mult_result: got v=%0b res=%h wb=%0d m=%0d wr=%0d st=%h br=%h z=%0b want 1/00010000/1/5/12/00010001/260/0",
               out_valid, alu_res, wb_out, m_out, write_reg, store_data, br_target, zero);
    end
    in_valid = 0;
    step();
    checks++;
    if (out_valid !== 0 || alu_res !== 32'h0001_0000) begin
      errors++;
      $display("FAIL mult_one_cycle: got v=%0b res=%h want 0/00010000", out_valid, alu_res);
    end
    idle_inputs();
  endtask

  task automatic test_abort_mult(input bit use_reset);
    int seen;
    idle_inputs();
    wb_in = 2'b11; m_in = 3'b111;
    in_valid = 1; alu_op = 3'b010; imm_in = 32'h18; rs_data = 32'hDEAD_BEEF; rt_data = 32'h1234_5677;
    step();
    for (int k = 0; k < 10; k++) step();
    checks++;
    if (stall !== 1) begin errors++; $display("FAIL abort_prestall: got %0b want 1", stall); end
    in_valid = 0;
    if (use_reset) reset = 1; else flush = 1;
    step();
    reset = 0; flush = 0;
    #1;
    checks++;
    if (stall !== 0 || out_valid !== 0 || wb_out !== 0 || m_out !== 0) begin
      errors++;
      $display("FAIL abort_state(rst=%0b): got stall=%0b v=%0b wb=%0d m=%0d want 0/0/0/0",
               use_reset, stall, out_valid, wb_out, m_out);
    end
    if (use_reset) begin
      checks++;
      if (alu_res !== 0 || write_reg !== 0 || store_data !== 0) begin
        errors++;
        $display("FAIL abort_reset_data: got res=%h wr=%0d st=%h want 0", alu_res, write_reg, store_data);
      end
    end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (out_valid !== 0 || alu_res === 32'hDEAD_BEEF * 32'h1234_5677) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL abort_no_result(rst=%0b): got %0d emissions want 0", use_reset, seen); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, bb, c, d;
    int n;
    for (int k = 0; k < 4; k++) begin
      idle_inputs();
      a = $urandom(); bb = $urandom(); c = $urandom(); d = $urandom();
      if (k == 0) bb = 0;
      issue_mult(a, bb, n);
      checks++;
      if (n != 32) begin errors++; $display("FAIL b2b_stalls[%0d]: got %0d want 32", k, n); end
      step();
      checks++;
      if (out_valid !== 1 || alu_res !== a * bb || zero !== ((a * bb) == 0)) begin
        errors++;
        $display("FAIL b2b_mult[%0d]: got v=%0b res=%h z=%0b want 1/%h", k, out_valid, alu_res, zero, a * bb);
      end
      alu_op = 3'b000; alu_src = 0; rs_data = c; rt_data = d; reg_dst = 0; rt_in = 5'(k + 1);
      #1;
      checks++;
      if (stall !== 0) begin errors++; $display("FAIL b2b_stall_after[%0d]: got %0b want 0", k, stall); end
      step();
      checks++;
      if (out_valid !== 1 || alu_res !== c + d || write_reg !== 5'(k + 1)) begin
        errors++;
        $display("FAIL b2b_add[%0d]: got v=%0b res=%h wr=%0d want 1/%h/%0d", k, out_valid, alu_res, write_reg, c + d, k + 1);
      end
      alu_op = 3'b101;
      step();
      checks++;
      if (out_valid !== 1 || alu_res !== (($signed(c) < $signed(d)) ? 32'd1 : 32'd0)) begin
        errors++;
        $display("FAIL b2b_slt[%0d]: got v=%0b res=%h", k, out_valid, alu_res);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_alu_directed();
    test_random_alu();
    test_mult();
    test_abort_mult(1'b0);
    test_abort_mult(1'b1);
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
